// File: rtl/alu_input_ctrl_if.sv
// Operand/mode bundle between the raw board I/O and the ALU front end.
// The master drives raw switches and button; the slave returns clean values.
interface alu_input_ctrl_if;
  logic [7:0] Sw;
  logic       Btn0;
  logic [3:0] X;
  logic [3:0] Y;
  logic       Op;
  logic       Update;

  modport master (
    output Sw, Btn0,
    input  X, Y, Op, Update
  );

  modport slave (
    input  Sw, Btn0,
    output X, Y, Op, Update
  );
endinterface

// File: rtl/alu_input_ctrl.sv
// ALU front end: synchronises and debounces switches and mode button,
// latching clean X/Y operands and a toggled add/subtract mode bit.
module alu_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic              Clk,
  input logic              Rst,
  alu_input_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic [7:0]    sw_m, sw_s, sw_last;
  logic          btn_m, btn_s;
  logic [CW-1:0] scnt, bcnt, bcnt_n;
  logic [3:0]    x_q, y_q;
  logic          op_q, update_q;
  logic          sw_commit, toggle;
  state_t        state, state_n;

  // Two-flop synchronisers for the asynchronous switches and button.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sw_m  <= '0;
      sw_s  <= '0;
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sw_m  <= bus.Sw;
      sw_s  <= sw_m;
      btn_m <= bus.Btn0;
      btn_s <= btn_m;
    end
  end

  // Commit only once the whole vector has been stable and actually differs.
  assign sw_commit = (sw_s == sw_last) && (scnt == CMAX) &&
                     (sw_last != {y_q, x_q});

  // Switch debounce: any bit change restarts the count; count saturates.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sw_last <= '0;
      scnt    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      if (sw_s != sw_last) begin
        sw_last <= sw_s;
        scnt    <= '0;
      end else if (scnt != CMAX) begin
        scnt <= scnt + 1'b1;
      end
      if (sw_commit) begin
        {y_q, x_q} <= sw_last;
      end
    end
  end

  // Button FSM next state; the toggle fires once per accepted press.
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    toggle  = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          bcnt_n  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (bcnt == CMAX) begin
          state_n = HELD;
          toggle  = 1'b1;
        end else begin
          bcnt_n = bcnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          bcnt_n  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_n = HELD;
        end else if (bcnt == CMAX) begin
          state_n = IDLE;
        end else begin
          bcnt_n = bcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state, mode bit and the merged one-cycle update pulse.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      bcnt     <= '0;
      op_q     <= 1'b0;
      update_q <= 1'b0;
    end else begin
      state    <= state_n;
      bcnt     <= bcnt_n;
      if (toggle) begin
        op_q <= ~op_q;
      end
      update_q <= sw_commit | toggle;
    end
  end

  assign bus.X      = x_q;
  assign bus.Y      = y_q;
  assign bus.Op     = op_q;
  assign bus.Update = update_q;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Scoreboard bench for alu_input_ctrl with DEBOUNCE_CYCLES=4.
// Stimulus pushes expected updates; a negedge monitor pops and compares.
module tb_alu_input_ctrl;

  localparam int N = 4;
  localparam int LAT = N + 3;

  typedef struct {
    int         cyc;
    logic [3:0] x;
    logic [3:0] y;
    logic       op;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t sb[$];
  logic [8:0] prev = '0;

  alu_input_ctrl_if bus ();

  alu_input_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(int c, logic [3:0] x, logic [3:0] y, logic op);
    exp_t e;
    e.cyc = c;
    e.x   = x;
    e.y   = y;
    e.op  = op;
    sb.push_back(e);
  endtask

  // Monitor: every output change must coincide with Update, and every
  // Update must match the next scoreboard entry.
  always @(negedge clk) begin
    logic [8:0] cur;
    exp_t e;
    cur = {bus.Op, bus.Y, bus.X};
    if (!rst_q) begin
      chk("change_vs_update", int'(cur != prev), int'(bus.Update));
      if (bus.Update) begin
        if (sb.size() == 0) begin
          chk("unexpected_update", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("update_cycle", cyc, e.cyc);
          chk("x", int'(bus.X), int'(e.x));
          chk("y", int'(bus.Y), int'(e.y));
          chk("op", int'(bus.Op), int'(e.op));
        end
      end
    end
    prev = cur;
  end

  initial begin
    int e0;
    bus.Sw   = '0;
    bus.Btn0 = 1'b0;

    // Reset values during and after a 3-cycle reset.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_x", int'(bus.X), 0);
      chk("rst_op", int'(bus.Op), 0);
      chk("rst_upd", int'(bus.Update), 0);
    end
    rst = 1'b0;
    step(4);
    chk("post_rst_xy", int'({bus.Y, bus.X}), 0);
    chk("post_rst_op", int'(bus.Op), 0);

    // Clean operand load.
    e0 = cyc;
    bus.Sw = 8'b0010_0111;
    expect_at(e0 + LAT, 4'd7, 4'd2, 1'b0);
    step(15);

    // Clean press held 20 cycles, then a second press.
    e0 = cyc;
    bus.Btn0 = 1'b1;
    expect_at(e0 + LAT, 4'd7, 4'd2, 1'b1);
    step(20);
    bus.Btn0 = 1'b0;
    step(10);
    e0 = cyc;
    bus.Btn0 = 1'b1;
    expect_at(e0 + LAT, 4'd7, 4'd2, 1'b0);
    step(12);
    bus.Btn0 = 1'b0;
    step(12);

    // Short 3-cycle glitch is rejected.
    bus.Btn0 = 1'b1;
    step(3);
    bus.Btn0 = 1'b0;
    step(12);

    // Accepted press followed by a bouncing release.
    e0 = cyc;
    bus.Btn0 = 1'b1;
    expect_at(e0 + LAT, 4'd7, 4'd2, 1'b1);
    step(12);
    bus.Btn0 = 1'b0;
    step(2);
    bus.Btn0 = 1'b1;
    step(1);
    bus.Btn0 = 1'b0;
    step(12);

    // Sw[1] bounce, then settle on a new value.
    for (int i = 0; i < 5; i++) begin
      bus.Sw = bus.Sw ^ 8'h02;
      step(2);
    end
    e0 = cyc;
    bus.Sw = 8'b0110_0101;
    expect_at(e0 + LAT, 4'd5, 4'd6, 1'b1);
    step(14);

    // Bounce that returns to the committed value: no update.
    bus.Sw = 8'h64;
    step(2);
    bus.Sw = 8'h65;
    step(14);

    // Reset in the middle of a press; button stays high.
    e0 = cyc;
    bus.Btn0 = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_xy", int'({bus.Y, bus.X}), 0);
    chk("midrst_op", int'(bus.Op), 0);
    chk("midrst_upd", int'(bus.Update), 0);
    expect_at(e0 + 5 + LAT, 4'd5, 4'd6, 1'b1);
    step(14);
    bus.Btn0 = 1'b0;
    step(12);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
